// File: rtl/param_line_buffer_pkg.sv
// Shared types and sizing helpers for the parameterised line buffer.
// LINE_BUF_PAD_EN selects zero-padded "same" windows instead of valid-only windows.
package param_line_buffer_pkg;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_READ = 2'd2
  } lb_state_e;

  function automatic int unsigned lb_ptr_w(input int unsigned line_w);
    return (line_w > 1) ? $clog2(line_w) : 1;
  endfunction

  // Windows per line and left-edge column offset of a window
  function automatic int unsigned lb_num_win(input int unsigned line_w, input int unsigned kernel_w);
`ifdef LINE_BUF_PAD_EN
    return line_w + 0 * kernel_w;
`else
    return line_w - kernel_w + 1;
`endif
  endfunction

  function automatic int unsigned lb_pad_off(input int unsigned kernel_w);
`ifdef LINE_BUF_PAD_EN
    return (kernel_w - 1) / 2;
`else
    return 0 * kernel_w;
`endif
  endfunction

endpackage

// File: rtl/param_line_buffer_if.sv
// Pixel write / window read bus between the row controller and one line buffer.
interface param_line_buffer_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned KERNEL_W = 3
);
  logic [DATA_W-1:0]          i_data;
  logic                       i_data_valid;
  logic                       o_wr_ready;
  logic                       i_rd_data;
  logic [KERNEL_W*DATA_W-1:0] o_data;
  logic                       o_data_valid;
  logic                       o_line_full;
  logic                       o_line_done;

  modport master (
    output i_data, i_data_valid, i_rd_data,
    input  o_wr_ready, o_data, o_data_valid, o_line_full, o_line_done
  );

  modport slave (
    input  i_data, i_data_valid, i_rd_data,
    output o_wr_ready, o_data, o_data_valid, o_line_full, o_line_done
  );
endinterface

// File: rtl/param_line_buffer_tap_sel.sv
// Combinational window extraction: KERNEL_W taps starting at rptr, leftmost tap in MSBs.
// Under LINE_BUF_PAD_EN the window is centred and out-of-line columns read as zero.
module param_line_buffer_tap_sel
  import param_line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_W   = 512,
  parameter int unsigned KERNEL_W = 3,
  parameter int unsigned PTR_W    = 9
) (
  input  logic [LINE_W-1:0][DATA_W-1:0] pix_i,
  input  logic [PTR_W-1:0]              rptr_i,
  output logic [KERNEL_W*DATA_W-1:0]    win_c
);

  localparam int PAD_OFF = int'(lb_pad_off(KERNEL_W));

  int col;

  always_comb begin
    win_c = '0;
    col   = 0;
    for (int k = 0; k < int'(KERNEL_W); k++) begin
      col = int'(rptr_i) + k - PAD_OFF;
      if (col >= 0 && col < int'(LINE_W))
        win_c[(int'(KERNEL_W) - k) * int'(DATA_W) - 1 -: DATA_W] = pix_i[PTR_W'(col)];
    end
  end

endmodule

// File: rtl/param_line_buffer.sv
// Single-line pixel buffer: fills LINE_W pixels, then returns one KERNEL_W window per read.
// Build option LINE_BUF_PAD_EN: LINE_W zero-padded windows instead of LINE_W-KERNEL_W+1.
module param_line_buffer
  import param_line_buffer_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_W   = 512,
  parameter int unsigned KERNEL_W = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  param_line_buffer_if.slave   bus
);

  localparam int unsigned PTR_W   = lb_ptr_w(LINE_W);
  localparam int unsigned NUM_WIN = lb_num_win(LINE_W, KERNEL_W);
  localparam int unsigned WIN_W   = KERNEL_W * DATA_W;

  lb_state_e                     state_q;
  logic [PTR_W-1:0]              wptr_q;
  logic [PTR_W-1:0]              rptr_q;
  logic [LINE_W-1:0][DATA_W-1:0] mem_q;
  logic [WIN_W-1:0]              data_q;
  logic                          valid_q;
  logic                          done_q;
  logic [WIN_W-1:0]              win_c;

  param_line_buffer_tap_sel #(
    .DATA_W   (DATA_W),
    .LINE_W   (LINE_W),
    .KERNEL_W (KERNEL_W),
    .PTR_W    (PTR_W)
  ) u_tap_sel (
    .pix_i  (mem_q),
    .rptr_i (rptr_q),
    .win_c  (win_c)
  );

  // Pixel storage has no reset; the FSM never reads it before a complete fill
  always_ff @(posedge i_clk) begin
    if (state_q == ST_FILL && bus.i_data_valid)
      mem_q[wptr_q] <= bus.i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_FILL;
      wptr_q  <= '0;
      rptr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_FILL: begin
          if (bus.i_data_valid) begin
            if (wptr_q == PTR_W'(LINE_W - 1)) begin
              wptr_q  <= '0;
              state_q <= ST_FULL;
            end else begin
              wptr_q <= wptr_q + 1'b1;
            end
          end
        end
        ST_FULL, ST_READ: begin
          // Writes are dropped here; only reads advance
          if (bus.i_rd_data) begin
            data_q  <= win_c;
            valid_q <= 1'b1;
            if (rptr_q == PTR_W'(NUM_WIN - 1)) begin
              rptr_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ST_FILL;
            end else begin
              rptr_q  <= rptr_q + 1'b1;
              state_q <= ST_READ;
            end
          end
        end
        default: state_q <= ST_FILL;
      endcase
    end
  end

  assign bus.o_wr_ready   = (state_q == ST_FILL);
  assign bus.o_line_full  = (state_q != ST_FILL);
  assign bus.o_data       = data_q;
  assign bus.o_data_valid = valid_q;
  assign bus.o_line_done  = done_q;

endmodule

// File: tb/tb_param_line_buffer.sv
// Directed bench for param_line_buffer (DATA_W=8, LINE_W=8, KERNEL_W=3); honours LINE_BUF_PAD_EN.
module tb_param_line_buffer;

  typedef struct {
    logic       dv;
    logic [7:0] d;
    logic       rd;
    logic       rdy;
    logic       full;
    logic       vld;
    logic [23:0] data;
    logic       done;
  } vec_t;

`ifdef LINE_BUF_PAD_EN
  localparam int NW = 8;
  localparam logic [23:0] EXP_WIN [8] = '{24'h001011, 24'h101112, 24'h111213, 24'h121314,
                                          24'h131415, 24'h141516, 24'h151617, 24'h161700};
  localparam logic [23:0] FIRST30 = 24'h003031;
  localparam logic [23:0] LAST30  = 24'h363700;
  localparam logic [23:0] FIRST20 = 24'h002021;
`else
  localparam int NW = 6;
  localparam logic [23:0] EXP_WIN [6] = '{24'h101112, 24'h111213, 24'h121314,
                                          24'h131415, 24'h141516, 24'h151617};
  localparam logic [23:0] FIRST30 = 24'h303132;
  localparam logic [23:0] LAST30  = 24'h353637;
  localparam logic [23:0] FIRST20 = 24'h202122;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[$];

  param_line_buffer_if #(.DATA_W(8), .KERNEL_W(3)) bus ();

  param_line_buffer #(.DATA_W(8), .LINE_W(8), .KERNEL_W(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic dv, input logic [7:0] d, input logic rd,
                              input logic rdy, input logic full, input logic vld,
                              input logic [23:0] data, input logic done);
    vec_t v;
    v.dv = dv; v.d = d; v.rd = rd; v.rdy = rdy; v.full = full;
    v.vld = vld; v.data = data; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic rdy, input logic full, input logic vld,
                         input logic [23:0] data, input logic done);
    chk({tag, "_wr_ready"},   32'(bus.o_wr_ready),   32'(rdy));
    chk({tag, "_line_full"},  32'(bus.o_line_full),  32'(full));
    chk({tag, "_data_valid"}, 32'(bus.o_data_valid), 32'(vld));
    chk({tag, "_data"},       32'(bus.o_data),       32'(data));
    chk({tag, "_line_done"},  32'(bus.o_line_done),  32'(done));
  endtask

  // Drive one cycle of inputs; return 1 ns after the rising edge
  task automatic cyc(input logic dv, input logic [7:0] d, input logic rd);
    bus.i_data_valid = dv;
    bus.i_data       = d;
    bus.i_rd_data    = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [7:0] base, input string tag);
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(base + 8'(i)), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk({tag, "_full_after_fill"}, 32'(bus.o_line_full), 32'd1);
  endtask

  initial begin
    logic [23:0] last;
    logic        got_done;
    int          n_rd;

    rst_n = 1'b0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = 8'h00;
    bus.i_rd_data    = 1'b0;
    #20;
    rst_n = 1'b1;
    exp_out("reset", 1'b1, 1'b0, 1'b0, 24'h0, 1'b0);

    // Fill with gaps carrying 0xEE, a dropped write, then a full read sweep
    for (int i = 0; i < 8; i++) begin
      vt.push_back(mk(1'b1, 8'(16 + i), 1'b0, (i < 7), (i == 7), 1'b0, 24'h0, 1'b0));
      vt.push_back(mk(1'b0, 8'hEE,      1'b0, (i < 7), (i == 7), 1'b0, 24'h0, 1'b0));
    end
    vt.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 24'h0, 1'b0));
    for (int r = 0; r < NW; r++)
      vt.push_back(mk(1'b0, 8'h00, 1'b1, (r == NW - 1), (r != NW - 1), 1'b1, EXP_WIN[r], (r == NW - 1)));
    vt.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, EXP_WIN[NW - 1], 1'b0));
    vt.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, EXP_WIN[NW - 1], 1'b0));

    foreach (vt[i]) begin
      cyc(vt[i].dv, vt[i].d, vt[i].rd);
      exp_out($sformatf("vec%0d", i), vt[i].rdy, vt[i].full, vt[i].vld, vt[i].data, vt[i].done);
    end

    // Line was consumed: the next write goes to a fresh line
    fill(8'h30, "t4");
    cyc(1'b1, 8'hAA, 1'b1);
    exp_out("t4_rd_wr", 1'b0, 1'b1, 1'b1, FIRST30, 1'b0);
    got_done = 1'b0;
    n_rd = 1;
    last = 24'h0;
    for (int i = 0; i < 12 && !got_done; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      n_rd++;
      last = bus.o_data;
      got_done = bus.o_line_done;
    end
    chk("t4_done_seen", 32'(got_done), 32'd1);
    chk("t4_num_reads", 32'(n_rd), 32'(NW));
    chk("t4_last_win", 32'(last), 32'(LAST30));
    chk("t4_ready_at_done", 32'(bus.o_wr_ready), 32'd1);

    // Asynchronous reset mid-read, then refill
    fill(8'h40, "t6");
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_pre_rst_valid", 32'(bus.o_data_valid), 32'd1);
    bus.i_rd_data = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_out("t6_rst", 1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
    #3;
    rst_n = 1'b1;
    cyc(1'b0, 8'h00, 1'b1);
    exp_out("t6_rd_after_rst", 1'b1, 1'b0, 1'b0, 24'h0, 1'b0);
    fill(8'h20, "t6b");
    cyc(1'b0, 8'h00, 1'b1);
    exp_out("t6_first_win", 1'b0, 1'b1, 1'b1, FIRST20, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
